// File: rtl/decode_window_ctrl_if.sv
// Bundle of the prefetch-side and decoder-side signals of decode_window_ctrl.
//   master : driven by the prefetch unit / decoder (fetch, consume, error, flush)
//   slave  : the queue itself (ready, window, level, decode_valid, eip, fault)
// Fetch:   i_fetch_valid, i_fetch_data[31:0], i_fetch_bytes[2:0] -> o_fetch_ready
// Decode:  o_instruction[0:15], o_level[5:0], o_decode_valid, i_consume_valid,
//          i_consume_bytes[3:0], i_decode_error
// Control: i_flush, i_flush_eip[31:0], o_eip[31:0], o_fault, o_fault_eip[31:0]
interface decode_window_ctrl_if;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_data;
  logic [2:0]  i_fetch_bytes;
  logic        o_fetch_ready;
  logic [7:0]  o_instruction [0:15];
  logic [5:0]  o_level;
  logic        o_decode_valid;
  logic        i_consume_valid;
  logic [3:0]  i_consume_bytes;
  logic        i_decode_error;
  logic        i_flush;
  logic [31:0] i_flush_eip;
  logic [31:0] o_eip;
  logic        o_fault;
  logic [31:0] o_fault_eip;

  modport master (
    output i_fetch_valid, i_fetch_data, i_fetch_bytes,
    output i_consume_valid, i_consume_bytes, i_decode_error,
    output i_flush, i_flush_eip,
    input  o_fetch_ready, o_instruction, o_level, o_decode_valid,
    input  o_eip, o_fault, o_fault_eip
  );

  modport slave (
    input  i_fetch_valid, i_fetch_data, i_fetch_bytes,
    input  i_consume_valid, i_consume_bytes, i_decode_error,
    input  i_flush, i_flush_eip,
    output o_fetch_ready, o_instruction, o_level, o_decode_valid,
    output o_eip, o_fault, o_fault_eip
  );
endinterface

// File: rtl/decode_window_ctrl.sv
// Byte-granular instruction queue feeding the decode pipeline. Accepts up to
// 4 fetched bytes per cycle into a DEPTH-byte circular buffer, presents a
// 16-byte window starting at the head, retires decoded instruction lengths
// and tracks the EIP of the head byte.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset (overrides flush)
//   bus     : decode_window_ctrl_if.slave (fetch, window, consume, flush, fault)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_FILL   | fewer than 16 bytes held, window not decodable
// ST_DECODE | window fully populated, decoder may retire instructions
// ST_FAULT  | decode error or zero-length consume seen; frozen until flush
module decode_window_ctrl #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] RESET_EIP = 32'h0000_FFF0
) (
  input logic             i_clk,
  input logic             i_reset,
  decode_window_ctrl_if.slave bus
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LW  = PW + 1;
  localparam int unsigned WIN = 16;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_DECODE = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    qbuf [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level, level_next;
  logic [31:0]   eip, fault_eip;

  logic          fetch_ready, decode_valid, fault_go;
  logic [2:0]    push_n;
  logic [3:0]    pop_n;

  // Ready uses the current level only, so a full 4-byte push always fits.
  assign fetch_ready  = level <= LW'(DEPTH - 4);
  assign decode_valid = (state == ST_DECODE) && (level >= LW'(WIN));

  always_comb begin
    push_n     = 3'd0;
    pop_n      = 4'd0;
    fault_go   = 1'b0;
    state_next = state;

    if (bus.i_fetch_valid && fetch_ready &&
        bus.i_fetch_bytes != 3'd0 && bus.i_fetch_bytes <= 3'd4)
      push_n = bus.i_fetch_bytes;

    // A zero-length consume faults and, having length 0, retires nothing.
    fault_go = decode_valid &&
               (bus.i_decode_error ||
                (bus.i_consume_valid && bus.i_consume_bytes == 4'd0));
    if (decode_valid && bus.i_consume_valid && !bus.i_decode_error)
      pop_n = bus.i_consume_bytes;

    level_next = level - LW'(pop_n) + LW'(push_n);

    case (state)
      ST_FILL:   if (level_next >= LW'(WIN)) state_next = ST_DECODE;
      ST_DECODE: begin
        if (fault_go)                    state_next = ST_FAULT;
        else if (level_next < LW'(WIN))  state_next = ST_FILL;
      end
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_FILL;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      eip       <= RESET_EIP;
      fault_eip <= 32'h0;
    end else if (bus.i_flush) begin
      state     <= ST_FILL;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      eip       <= bus.i_flush_eip;
    end else begin
      state  <= state_next;
      level  <= level_next;
      rd_ptr <= rd_ptr + PW'(pop_n);
      wr_ptr <= wr_ptr + PW'(push_n);
      eip    <= eip + 32'(pop_n);
      if (fault_go) fault_eip <= eip;
    end
  end

  // Storage needs no reset: bytes beyond level are masked in the window.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !bus.i_flush) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < push_n)
          qbuf[wr_ptr + PW'(j)] <= bus.i_fetch_data[8*j +: 8];
      end
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_win
    assign bus.o_instruction[k] = (LW'(k) < level) ? qbuf[rd_ptr + PW'(k)] : 8'h00;
  end

  assign bus.o_fetch_ready  = fetch_ready;
  assign bus.o_level        = 6'(level);
  assign bus.o_decode_valid = decode_valid;
  assign bus.o_eip          = eip;
  assign bus.o_fault        = (state == ST_FAULT);
  assign bus.o_fault_eip    = fault_eip;

endmodule

// File: tb/tb_decode_window_ctrl.sv
module tb_decode_window_ctrl;
  localparam logic [31:0] RST_EIP = 32'h0000_FFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_window_ctrl_if bus();

  decode_window_ctrl #(.DEPTH(32), .RESET_EIP(RST_EIP)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Reference model: the queue is literally a queue of bytes.
  logic [7:0]  mq [$];
  logic [31:0] m_eip  = RST_EIP;
  logic [31:0] m_feip = 32'h0;
  bit          m_fault = 1'b0;
  bit          chk_en  = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int lvl;
      lvl = mq.size();
      check("level", 32'(bus.o_level), 32'(lvl));
      check("fetch_ready", 32'(bus.o_fetch_ready), 32'(lvl <= 28));
      check("decode_valid", 32'(bus.o_decode_valid), 32'(!m_fault && lvl >= 16));
      check("fault", 32'(bus.o_fault), 32'(m_fault));
      check("eip", bus.o_eip, m_eip);
      check("fault_eip", bus.o_fault_eip, m_feip);
      for (int k = 0; k < 16; k++)
        check($sformatf("win[%0d]", k), 32'(bus.o_instruction[k]),
              (k < lvl) ? 32'(mq[k]) : 32'h0);
    end
  end

  task automatic step(input bit r, input bit fv, input logic [31:0] fd, input logic [2:0] fb,
                      input bit cv, input logic [3:0] cb, input bit de,
                      input bit fl, input logic [31:0] fe);
    int lvl;
    bit dv, rdy;
    rst                 = r;
    bus.i_fetch_valid   = fv;
    bus.i_fetch_data    = fd;
    bus.i_fetch_bytes   = fb;
    bus.i_consume_valid = cv;
    bus.i_consume_bytes = cb;
    bus.i_decode_error  = de;
    bus.i_flush         = fl;
    bus.i_flush_eip     = fe;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_eip = RST_EIP; m_fault = 1'b0; m_feip = 32'h0;
    end else if (fl) begin
      mq.delete(); m_eip = fe; m_fault = 1'b0;
    end else begin
      lvl = mq.size();
      dv  = !m_fault && lvl >= 16;
      rdy = lvl <= 28;
      if (dv && de) begin
        m_fault = 1'b1; m_feip = m_eip;
      end else if (dv && cv) begin
        if (cb == 4'd0) begin
          m_fault = 1'b1; m_feip = m_eip;
        end else begin
          for (int j = 0; j < int'(cb); j++) void'(mq.pop_front());
          m_eip = m_eip + 32'(cb);
        end
      end
      if (fv && rdy && fb >= 3'd1 && fb <= 3'd4)
        for (int j = 0; j < int'(fb); j++) mq.push_back(fd[8*j +: 8]);
    end
    #1;
  endtask

  function automatic logic [31:0] seq4(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic push(input logic [31:0] d, input logic [2:0] n);
    step(0, 1, d, n, 0, 4'd0, 0, 0, 32'h0);
  endtask

  task automatic flush(input logic [31:0] fe);
    step(0, 0, 32'h0, 3'd0, 0, 4'd0, 0, 1, fe);
  endtask

  initial begin
    int nb;
    bus.i_fetch_valid = 0; bus.i_fetch_data = 0; bus.i_fetch_bytes = 0;
    bus.i_consume_valid = 0; bus.i_consume_bytes = 0; bus.i_decode_error = 0;
    bus.i_flush = 0; bus.i_flush_eip = 0;

    // Reset state
    step(1, 0, 32'h0, 3'd0, 0, 4'd0, 0, 0, 32'h0);
    chk_en = 1'b1;
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_ready", 32'(bus.o_fetch_ready), 32'd1);
    check("rst_dv", 32'(bus.o_decode_valid), 32'd0);
    check("rst_eip", bus.o_eip, 32'h0000_FFF0);

    // Four full pushes: decode_valid after the 4th
    for (int i = 0; i < 4; i++) begin
      push(seq4(4 * i), 3'd4);
      if (i == 2) check("dv_after3", 32'(bus.o_decode_valid), 32'd0);
    end
    check("dv_after4", 32'(bus.o_decode_valid), 32'd1);
    check("win0_00", 32'(bus.o_instruction[0]), 32'h00);
    check("win15_0f", 32'(bus.o_instruction[15]), 32'h0F);
    check("eip_fff0", bus.o_eip, 32'h0000_FFF0);

    // Fill to 32, then consume 3 with a push that must be refused
    for (int i = 4; i < 8; i++) push(seq4(4 * i), 3'd4);
    check("full_level", 32'(bus.o_level), 32'd32);
    check("full_ready", 32'(bus.o_fetch_ready), 32'd0);
    step(0, 1, 32'hDEAD_BEEF, 3'd4, 1, 4'd3, 0, 0, 32'h0);
    check("c3_level", 32'(bus.o_level), 32'd29);
    check("c3_head", 32'(bus.o_instruction[0]), 32'h03);
    check("c3_eip", bus.o_eip, 32'h0000_FFF3);
    push(32'h1111_1111, 3'd4);
    check("l29_refused", 32'(bus.o_level), 32'd29);

    // 7-byte instruction stream across many pointer wraps
    nb = 8'h20;
    for (int c = 0; c < 60; c++) begin
      logic [2:0] n;
      n = 3'((c % 4) + 1);
      step(0, 1, seq4(nb), n, 1, 4'd7, 0, 0, 32'h0);
      // Byte numbering only advances on acceptance; model decides acceptance too.
      if (mq.size() > 0 && mq[mq.size() - 1] == 8'(nb + int'(n) - 1)) nb += int'(n);
    end

    // Decode error fault and flush recovery
    flush(32'h0000_1234);
    for (int i = 0; i < 4; i++) push(seq4(8'h40 + 4 * i), 3'd4);
    check("err_pre_dv", 32'(bus.o_decode_valid), 32'd1);
    step(0, 0, 32'h0, 3'd0, 1, 4'd5, 1, 0, 32'h0);
    check("err_fault", 32'(bus.o_fault), 32'd1);
    check("err_feip", bus.o_fault_eip, 32'h0000_1234);
    push(seq4(8'h50), 3'd4);
    push(seq4(8'h54), 3'd4);
    check("fault_dv", 32'(bus.o_decode_valid), 32'd0);
    check("fault_level", 32'(bus.o_level), 32'd24);
    flush(32'h0000_8000);
    check("fl_fault", 32'(bus.o_fault), 32'd0);
    check("fl_level", 32'(bus.o_level), 32'd0);
    check("fl_eip", bus.o_eip, 32'h0000_8000);

    // Flush beats same-cycle push and consume
    for (int i = 0; i < 4; i++) push(seq4(8'h60 + 4 * i), 3'd4);
    step(0, 1, 32'h9999_9999, 3'd4, 1, 4'd3, 0, 1, 32'hABCD_0001);
    check("flw_level", 32'(bus.o_level), 32'd0);
    check("flw_eip", bus.o_eip, 32'hABCD_0001);
    check("flw_win0", 32'(bus.o_instruction[0]), 32'h00);

    // Partial pushes pack contiguously after an unaligned flush
    flush(32'h0000_1003);
    push(32'h0000_00AA, 3'd1);
    push(32'h00DD_CCBB, 3'd3);
    check("pk_level", 32'(bus.o_level), 32'd4);
    check("pk_w0", 32'(bus.o_instruction[0]), 32'hAA);
    check("pk_w1", 32'(bus.o_instruction[1]), 32'hBB);
    check("pk_w3", 32'(bus.o_instruction[3]), 32'hDD);
    check("pk_w4", 32'(bus.o_instruction[4]), 32'h00);
    push(32'h1234_5678, 3'd0);
    push(32'h1234_5678, 3'd5);
    check("bad_nbytes", 32'(bus.o_level), 32'd4);
    step(0, 0, 32'h0, 3'd0, 1, 4'd2, 0, 0, 32'h0);
    check("consume_ign_eip", bus.o_eip, 32'h0000_1003);

    // Zero-length consume faults
    for (int i = 0; i < 3; i++) push(seq4(8'h70 + 4 * i), 3'd4);
    step(0, 0, 32'h0, 3'd0, 1, 4'd0, 0, 0, 32'h0);
    check("z_fault", 32'(bus.o_fault), 32'd1);
    check("z_feip", bus.o_fault_eip, 32'h0000_1003);

    // Reset mid-stream overrides flush and push
    step(1, 1, 32'h5555_5555, 3'd4, 1, 4'd2, 0, 1, 32'h7777_0000);
    check("mr_level", 32'(bus.o_level), 32'd0);
    check("mr_fault", 32'(bus.o_fault), 32'd0);
    check("mr_eip", bus.o_eip, 32'h0000_FFF0);
    check("mr_feip", bus.o_fault_eip, 32'h0);
    check("mr_ready", 32'(bus.o_fetch_ready), 32'd1);

    step(0, 0, 32'h0, 3'd0, 0, 4'd0, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
